// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I field bundles (OP-IMM, OP, BRANCH) back
// into 32-bit instruction words. Each word is tagged with a word-aligned
// program-memory byte address and buffered in a 2-entry output FIFO.
//
// Optional feature: define INSTR_ENC_RANGE_CHECK_EN to drop bundles whose
// immediate does not fit the encoded field. Without it, immediates are
// truncated to the encoded bits.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         field bundle handshake (in_ready from occupancy)
//   in_class                  00 OP-IMM, 01 OP, 10 BRANCH, 11 reserved
//   in_rd/in_rs1/in_rs2       register fields
//   in_func3/in_funcqual      func3 and qualifier (instr[30])
//   in_imm                    sign-extended immediate
//   out_valid/out_ready       FIFO head handshake
//   out_instr/out_addr        encoded word and its byte address
//   err/err_clr               sticky drop flag and its synchronous clear
//   level                     FIFO occupancy 0..2
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic              in_funcqual,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr,
  output logic [1:0]        level
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0]       r_mem_instr [0:1];
  logic [ADDR_W-1:0] r_mem_addr  [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_level;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_err;

  logic        w_is_shift;
  logic        w_reserved;
  logic        w_range_bad;
  logic [31:0] w_instr;
  logic        w_accept;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;

  assign w_is_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);
  assign w_reserved = (in_class == 2'b11);

  // Field packing; funcqual only reaches instr[30] for OP and OP-IMM shifts.
  always_comb begin
    w_instr = 32'h0;
    case (in_class)
      2'b00: begin
        if (w_is_shift) begin
          w_instr = {1'b0, in_funcqual, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, OPC_OPIMM};
        end else begin
          w_instr = {in_imm[11:0], in_rs1, in_func3, in_rd, OPC_OPIMM};
        end
      end
      2'b01: w_instr = {1'b0, in_funcqual, 5'b0, in_rs2, in_rs1, in_func3, in_rd, OPC_OP};
      2'b10: w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                        in_imm[4:1], in_imm[11], OPC_BRANCH};
      default: w_instr = 32'h0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Immediate must be representable in the field it is packed into.
  always_comb begin
    w_range_bad = 1'b0;
    case (in_class)
      2'b00: begin
        if (w_is_shift) begin
          w_range_bad = |in_imm[31:5];
        end else begin
          w_range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
        end
      end
      2'b10: w_range_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      default: w_range_bad = 1'b0;
    endcase
  end
`else
  // Upper immediate bits are simply truncated in this build.
  logic w_unused_imm;
  assign w_unused_imm = ^in_imm[31:13];
  assign w_range_bad  = 1'b0;
`endif

  assign in_ready = (r_level < 2'd2);
  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && (w_reserved || w_range_bad);
  assign w_push   = w_accept && !w_drop;
  assign w_pop    = out_valid && out_ready;

  // FIFO storage, pointers, occupancy, address counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_instr[i] <= 32'h0;
        r_mem_addr[i]  <= ADDR_W'(BASE_ADDR);
      end
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_level   <= 2'd0;
      r_wr_addr <= ADDR_W'(BASE_ADDR);
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= w_instr;
        r_mem_addr[r_wr_ptr]  <= r_wr_addr;
        r_wr_ptr              <= ~r_wr_ptr;
        r_wr_addr             <= r_wr_addr + ADDR_W'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 2'd1;
        2'b01:   r_level <= r_level - 2'd1;
        default: r_level <= r_level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_valid = (r_level != 2'd0);
  assign out_instr = r_mem_instr[r_rd_ptr];
  assign out_addr  = r_mem_addr[r_rd_ptr];
  assign err       = r_err;
  assign level     = r_level;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_class;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_func3;
  logic        in_funcqual;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err;
  logic        err_clr;
  logic [1:0]  level;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_addr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_funcqual(in_funcqual), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_clr(err_clr), .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a bundle, wait (bounded) for in_ready, complete one handshake.
  task automatic push(input logic [1:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic fq,
                      input logic [31:0] imm);
    in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_funcqual = fq; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Pop the head word (bounded wait) and check it against the running address.
  task automatic expect_word(input string tag, input logic [31:0] instr);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_addr = exp_addr + 8'd4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_class = 2'b00; in_rd = 5'd0; in_rs1 = 5'd0;
    in_rs2 = 5'd0; in_func3 = 3'd0; in_funcqual = 1'b0; in_imm = 32'd0;
    out_ready = 1'b0; err_clr = 1'b0; exp_addr = 8'h00;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic encodings, one word at a time.
    push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    chk("addi_level", 32'(level), 32'd1);
    expect_word("addi", 32'h00500093);
    push(2'b01, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
    expect_word("add", 32'h002081B3);
    push(2'b01, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
    expect_word("sub", 32'h402081B3);
    push(2'b00, 5'd5, 5'd5, 5'd0, 3'b101, 1'b1, 32'd3);
    expect_word("srai", 32'h4032D293);
    push(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFFFFF8);
    expect_word("beq", 32'hFE208CE3);
    // funcqual must not leak into non-shift OP-IMM.
    push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b1, 32'd5);
    expect_word("addi_fq", 32'h00500093);

    // Backpressure: two accepts fill the FIFO, the third is held.
    push(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1);
    push(2'b00, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2);
    chk("full_level", 32'(level), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_class = 2'b00; in_rd = 5'd4; in_rs1 = 5'd0; in_func3 = 3'b000;
    in_funcqual = 1'b0; in_imm = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("held_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    chk("bp0_instr", out_instr, 32'h00100113);
    chk("bp0_addr", 32'(out_addr), 32'(exp_addr));
    @(posedge clk); #1;
    chk("bp1_level", 32'(level), 32'd1);
    chk("bp1_instr", out_instr, 32'h00200193);
    chk("bp1_addr", 32'(out_addr), 32'(exp_addr + 8'd4));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp2_level", 32'(level), 32'd1);
    chk("bp2_instr", out_instr, 32'h00300213);
    chk("bp2_addr", 32'(out_addr), 32'(exp_addr + 8'd8));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_empty_level", 32'(level), 32'd0);
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    exp_addr = exp_addr + 8'd12;

    // Reserved class is dropped, consumes no address, sets err.
    push(2'b11, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0);
    chk("rsv_err", 32'(err), 32'd1);
    chk("rsv_level", 32'(level), 32'd0);
    push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    expect_word("after_rsv", 32'h00500093);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    // Drop coinciding with clear keeps err set.
    err_clr = 1'b1;
    push(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
    err_clr = 1'b0;
    chk("drop_vs_clr", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr2", 32'(err), 32'd0);

    // Out-of-range immediate for addi.
    push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("range_err", 32'(err), 32'd1);
    chk("range_level", 32'(level), 32'd0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
`else
    expect_word("imm2048", 32'h80000093);
    chk("norange_err", 32'(err), 32'd0);
`endif
    push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    expect_word("after_range", 32'h00500093);

    // Advance to 0xF4, then fill the FIFO so the counter sits at 0xFC.
    while (exp_addr != 8'hF4) begin
      push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
      expect_word("fill", 32'h00500093);
    end
    push(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    push(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1);
    chk("pre_rst_level", 32'(level), 32'd2);
    chk("pre_rst_addr", 32'(out_addr), 32'hF4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_addr", 32'(out_addr), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr = 8'h00;

    // 65 writes from 0x00: the last wraps back to 0x00.
    for (int i = 0; i < 65; i++) begin
      push(2'b00, 5'(i), 5'd0, 5'd0, 3'b000, 1'b0, 32'(i));
      expect_word("wrap", {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
